// File: rtl/key_remap_ctrl_pkg.sv
// Shared constants and state encoding for the note-key remap controller.
// State values are visible on state_o and decoded by the display logic.
package key_remap_ctrl_pkg;

  localparam int NOTE_KEY_BITS     = 7;
  localparam int REMAP_TIMEOUT_CYC = 500_000_000;
  localparam int REMAP_TMR_BITS    = 29;

  typedef enum logic [2:0] {
    ST_PLAY  = 3'd0,
    ST_SRC   = 3'd1,
    ST_DST   = 3'd2,
    ST_WRITE = 3'd3,
    ST_ACK   = 3'd4
  } state_t;

endpackage

// File: rtl/key_remap_ctrl_if.sv
// Port bundle toward the remap table RAM: write strobe, one-hot address, one-hot data.
// Single-cycle writes, no backpressure; the RAM accepts every strobe.
interface key_remap_ctrl_if #(
  parameter int NOTE_KEY_BITS = key_remap_ctrl_pkg::NOTE_KEY_BITS
);
  logic                     rw;
  logic [NOTE_KEY_BITS-1:0] addr;
  logic [NOTE_KEY_BITS-1:0] wdata;

  modport master (output rw, addr, wdata);
  modport slave  (input  rw, addr, wdata);
endinterface

// File: rtl/key_remap_ctrl_key_press_detect.sv
// Registers key levels and flags a fresh press (from all-released), split into single and chord.
// Flags are 1 cycle after keys reach keys_q; no backpressure.
module key_press_detect #(
  parameter int NOTE_KEY_BITS = key_remap_ctrl_pkg::NOTE_KEY_BITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NOTE_KEY_BITS-1:0] keys,
  output logic                     press_valid,
  output logic                     press_multi,
  output logic                     keys_idle,
  output logic [NOTE_KEY_BITS-1:0] key_onehot
);

  logic [NOTE_KEY_BITS-1:0] keys_q;
  logic [NOTE_KEY_BITS-1:0] keys_prev;
  logic                     press;
  logic                     is_one;

  function automatic int unsigned popcount(input logic [NOTE_KEY_BITS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < NOTE_KEY_BITS; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      keys_q    <= '0;
      keys_prev <= '0;
    end else begin
      keys_q    <= keys;
      keys_prev <= keys_q;
    end
  end

  // A press only counts when coming from all-released, so chords added later are ignored.
  assign press       = (keys_prev == '0) && (keys_q != '0);
  assign is_one      = (popcount(keys_q) == 1);
  assign press_valid = press && is_one;
  assign press_multi = press && !is_one;
  assign keys_idle   = (keys_q == '0);
  assign key_onehot  = is_one ? keys_q : '0;

endmodule

// File: rtl/key_remap_ctrl.sv
// Drives the remap table RAM: live read address in play mode, src/dst press dialogue + one write in remap mode.
// Play read path keys->ram_addr is 2 cycles; write strobe is a single cycle; no backpressure.
module key_remap_ctrl #(
  parameter int NOTE_KEY_BITS = key_remap_ctrl_pkg::NOTE_KEY_BITS,
  parameter int TIMEOUT_CYC   = key_remap_ctrl_pkg::REMAP_TIMEOUT_CYC,
  parameter int TMR_BITS      = key_remap_ctrl_pkg::REMAP_TMR_BITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     remap_en,
  input  logic [NOTE_KEY_BITS-1:0] keys,
  key_remap_ctrl_if.master         ram,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [2:0]               state_o
);
  import key_remap_ctrl_pkg::*;

  typedef logic [NOTE_KEY_BITS-1:0] key_t;

  state_t              state, state_n;
  logic [TMR_BITS-1:0] cnt, cnt_n;
  key_t                src, src_n;
  key_t                dst, dst_n;
  key_t                addr, addr_n;
  logic                err_n;
  logic                tmo;

  logic press_valid, press_multi, keys_idle;
  key_t key_onehot;

  key_press_detect #(.NOTE_KEY_BITS(NOTE_KEY_BITS)) u_detect (
    .clk         (clk),
    .rst_n       (rst_n),
    .keys        (keys),
    .press_valid (press_valid),
    .press_multi (press_multi),
    .keys_idle   (keys_idle),
    .key_onehot  (key_onehot)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_PLAY;
      cnt   <= '0;
      src   <= '0;
      dst   <= '0;
      addr  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      src   <= src_n;
      dst   <= dst_n;
      addr  <= addr_n;
      err   <= err_n;
    end
  end

  assign tmo = (cnt == TMR_BITS'(TIMEOUT_CYC - 1));

  always_comb begin
    state_n = state;
    cnt_n   = '0;
    src_n   = src;
    dst_n   = dst;
    addr_n  = addr;
    err_n   = 1'b0;
    case (state)
      ST_PLAY: begin
        addr_n = key_onehot;
        err_n  = press_multi;
        if (remap_en) begin
          state_n = ST_SRC;
          addr_n  = '0;
        end
      end
      ST_SRC: begin
        cnt_n = cnt + 1'b1;
        if (!remap_en) begin
          state_n = ST_PLAY;
        end else if (press_valid) begin
          src_n   = key_onehot;
          state_n = ST_DST;
        end else if (tmo) begin
          err_n = 1'b1;
          cnt_n = '0;
        end else begin
          err_n = press_multi;
        end
      end
      ST_DST: begin
        cnt_n = cnt + 1'b1;
        if (!remap_en) begin
          state_n = ST_PLAY;
        end else if (press_valid) begin
          dst_n   = key_onehot;
          addr_n  = src;
          state_n = ST_WRITE;
        end else if (tmo) begin
          err_n   = 1'b1;
          src_n   = '0;
          state_n = ST_SRC;
        end else begin
          err_n = press_multi;
        end
      end
      ST_WRITE: begin
        state_n = ST_ACK;
      end
      ST_ACK: begin
        err_n = press_multi;
        if (keys_idle) begin
          state_n = remap_en ? ST_SRC : ST_PLAY;
        end
      end
      default: begin
        state_n = ST_PLAY;
      end
    endcase
    // Every state entry restarts the timeout window.
    if (state_n != state) begin
      cnt_n = '0;
    end
    if (state_n == ST_PLAY && state != ST_PLAY) begin
      addr_n = key_onehot;
    end
  end

  assign ram.rw    = (state == ST_WRITE);
  assign ram.addr  = addr;
  assign ram.wdata = (state == ST_WRITE) ? dst : '0;
  assign done      = (state == ST_WRITE);
  assign busy      = (state != ST_PLAY);
  assign state_o   = state;

endmodule

// File: tb/tb_key_remap_ctrl.sv
// Randomized and directed stimulus against a timestamp-based dialogue model; write/err events
// are queued by the model and popped by a negedge monitor.
module tb_key_remap_ctrl;

  localparam int W  = 7;
  localparam int T  = 20;
  localparam int TB = 5;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         remap_en = 1'b0;
  logic [W-1:0] keys     = '0;
  logic         busy, done, err;
  logic [2:0]   state_o;

  key_remap_ctrl_if #(.NOTE_KEY_BITS(W)) ram ();

  key_remap_ctrl #(.NOTE_KEY_BITS(W), .TIMEOUT_CYC(T), .TMR_BITS(TB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .remap_en (remap_en),
    .keys     (keys),
    .ram      (ram),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    bit           is_wr;
    logic [W-1:0] a;
    logic [W-1:0] d;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  n_wr  = 0;
  int  cyc   = 0;

  // Model: mode 0 play, 1 waiting for source, 2 waiting for destination, 3 writing, 4 waiting release.
  int           mode     = 0;
  int           entry    = 0;
  logic [W-1:0] kq       = '0;
  logic [W-1:0] kp       = '0;
  logic [W-1:0] m_src    = '0;
  logic [W-1:0] addr_exp = '0;
  bit           addr_chk = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic ev_t mk_ev(input int c, input bit w, input logic [W-1:0] a, input logic [W-1:0] d);
    ev_t e;
    e.cyc = c; e.is_wr = w; e.a = a; e.d = d;
    return e;
  endfunction

  always @(posedge clk) begin : model
    bit press, one, multi;
    int nxt;
    cyc++;
    if (!rst_n) begin
      mode = 0; kq = '0; kp = '0; m_src = '0; entry = cyc;
      addr_exp = '0; addr_chk = 1'b1;
    end else begin
      press    = (kp == '0) && (kq != '0);
      one      = ($countones(kq) == 1);
      multi    = press && !one;
      nxt      = mode;
      addr_chk = 1'b0;
      case (mode)
        0: begin
          if (multi) exp_q.push_back(mk_ev(cyc, 1'b0, '0, '0));
          if (remap_en) begin
            nxt = 1; addr_exp = '0;
          end else begin
            addr_exp = one ? kq : '0;
          end
          addr_chk = 1'b1;
        end
        1, 2: begin
          if (!remap_en) nxt = 0;
          else if (press && one) begin
            if (mode == 1) begin
              m_src = kq; nxt = 2;
            end else begin
              exp_q.push_back(mk_ev(cyc, 1'b1, m_src, kq));
              nxt = 3;
            end
          end else if (cyc - entry == T) begin
            exp_q.push_back(mk_ev(cyc, 1'b0, '0, '0));
            entry = cyc;
            nxt = 1;
          end else if (multi) exp_q.push_back(mk_ev(cyc, 1'b0, '0, '0));
        end
        3: nxt = 4;
        default: begin
          if (multi) exp_q.push_back(mk_ev(cyc, 1'b0, '0, '0));
          if (kq == '0) nxt = remap_en ? 1 : 0;
        end
      endcase
      if (nxt == 3 || nxt == 4) begin
        addr_exp = m_src; addr_chk = 1'b1;
      end
      if (nxt != mode) entry = cyc;
      mode = nxt;
      kp = kq;
      kq = keys;
    end
  end

  always @(negedge clk) begin : monitor
    bit dut_ev, exp_ev;
    ev_t e;
    if (cyc > 0) begin
      chk("state_o", 32'(state_o), 32'(mode));
      chk("busy", 32'(busy), 32'(mode != 0));
      chk("ram_rw", 32'(ram.rw), 32'(mode == 3));
      chk("done", 32'(done), 32'(mode == 3));
      chk("addr_onehot", 32'($countones(ram.addr) <= 1), 32'(1));
      if (addr_chk) chk("ram_addr", 32'(ram.addr), 32'(addr_exp));
      dut_ev = err || ram.rw;
      exp_ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      if (dut_ev || exp_ev) begin
        if (!exp_ev) begin
          chk("unexpected_event", {30'd0, err, ram.rw}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", {30'd0, err, ram.rw}, e.is_wr ? 32'd1 : 32'd2);
          if (e.is_wr) begin
            n_wr++;
            chk("wr_addr", 32'(ram.addr), 32'(e.a));
            chk("wr_data", 32'(ram.wdata), 32'(e.d));
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_rel(input logic [W-1:0] k);
    keys = k; tick(2);
    keys = '0; tick(2);
  endtask

  initial begin
    tick(2);
    rst_n = 1'b1;
    // play read path
    keys = 7'b0000100; tick(4);
    keys = '0; tick(2);
    // normal remap, then multi-key reject and re-press
    remap_en = 1'b1; tick(3);
    press_rel(7'b0000001);
    press_rel(7'b0100000);
    tick(2);
    press_rel(7'b0000011);
    press_rel(7'b0000010);
    // destination timeout, then source timeout after a fresh destination timeout
    tick(30);
    press_rel(7'b0001000);
    tick(30);
    // abort from destination, re-enter and idle through a source timeout
    press_rel(7'b0000001);
    remap_en = 1'b0; tick(3);
    remap_en = 1'b1; tick(25);
    // reset while waiting for destination
    press_rel(7'b0000010);
    rst_n = 1'b0; tick(1);
    rst_n = 1'b1; remap_en = 1'b0;
    keys = 7'b0000100; tick(4);
    keys = '0; tick(2);
    remap_en = 1'b1;
    for (int i = 0; i < 700; i++) begin
      int r;
      int hold;
      r    = $urandom_range(0, 99);
      hold = $urandom_range(1, 6);
      if (r < 45) keys = '0;
      else if (r < 80) begin
        keys = '0;
        keys[$urandom_range(0, W-1)] = 1'b1;
      end else if (r < 95) keys = W'($urandom_range(3, 127));
      else begin
        keys = '0;
        hold = $urandom_range(18, 30);
      end
      if ($urandom_range(0, 24) == 0) remap_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0; tick(1); rst_n = 1'b1;
      end
      tick(hold);
    end
    keys = '0; tick(4);
    chk("events_drained", 32'(exp_q.size()), 32'd0);
    chk("writes_seen", 32'(n_wr > 2), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_remap_ctrl.md
Name: key_remap_ctrl

Overview:
- Control stage directly upstream of the note-key remap table RAM; it drives the RAM's rw, addr and in ports.
- In play mode it forwards the live one-hot key vector as the read address, so the table returns the remapped key.
- In remap mode it runs a two-press dialogue: press the source key, then the destination key, then issue one write cycle.
- Also handles multi-key rejection, timeout, abort and status reporting for the LED/seg display logic.

Parameters:
- NOTE_KEY_BITS, 7 (from Constants.vh): one-hot key vector width.
- TIMEOUT_CYC, 500_000_000: cycles allowed in SRC or DST before abandoning the dialogue (5 s at 100 MHz).
- TMR_BITS, 29: timeout counter width; must satisfy 2^TMR_BITS > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- remap_en  in  1  mode switch level; 1 = remap mode, 0 = play mode.
- keys  in  NOTE_KEY_BITS  debounced key levels, bit i = key i held.
- ram_rw  out  1  write strobe to the table RAM.
- ram_addr  out  NOTE_KEY_BITS  one-hot table address.
- ram_wdata  out  NOTE_KEY_BITS  one-hot data written to the table.
- busy  out  1  high in any state other than PLAY.
- done  out  1  one-cycle pulse when a write is issued.
- err  out  1  one-cycle pulse on multi-key press or timeout.
- state_o  out  3  current state encoding, for display.

Behaviour:
Reset:
- While rst_n=0 at posedge: state=PLAY; ram_rw, ram_addr, ram_wdata, done, err, busy, counter, src, dst, keys_q, keys_prev all 0.

Input stage:
- keys_q <= keys; keys_prev <= keys_q.
- Press event: keys_prev==0 && keys_q!=0.
- Valid press: press event && keys_q is exactly one-hot (popcount 1).
- Invalid press: press event with popcount>1. Pulses err, state unchanged.
- Keys held or chorded after a press do not generate further events until all keys are released.

States (state_o encoding): PLAY=0, SRC=1, DST=2, WRITE=3, ACK=4.
- PLAY:
  - ram_rw=0; ram_addr<=keys_q each cycle, so read latency from keys to addr is 2 cycles.
  - remap_en=1 -> SRC; ram_addr<=0 on that transition.
- SRC:
  - Counter increments each cycle.
  - Valid press: src<=keys_q, counter<=0, -> DST.
  - Counter==TIMEOUT_CYC-1: err pulse, counter<=0, stay in SRC.
- DST:
  - Counter increments each cycle.
  - Valid press: dst<=keys_q -> WRITE.
  - Timeout: err pulse, src discarded, counter<=0, -> SRC.
  - src==dst is legal (identity mapping).
- WRITE:
  - Exactly one cycle with ram_rw=1, ram_addr=src, ram_wdata=dst; done=1 in the same cycle.
  - Always -> ACK.
- ACK:
  - ram_rw=0, ram_addr=src held.
  - Waits for keys_q==0, then -> SRC (remap_en=1) or PLAY (remap_en=0).

Other rules:
- remap_en falling while in SRC or DST: -> PLAY next cycle; no write; no err.
- remap_en falling while in WRITE: the write completes, then ACK applies the rule above.
- Counter is cleared on every state entry and is only active in SRC and DST.
- ram_addr and ram_wdata are always 0 or one-hot; never multi-hot.
- ram_rw is never high outside WRITE and never high for 2 consecutive cycles.
- done and err never assert in the same cycle.
- Reset mid-dialogue: returns to PLAY, discards src/dst, issues no write. The table RAM reloads its identity map on the same rst_n.

Decomposition:
- Constants.vh: NOTE_KEY_BITS (existing); state encodings ST_PLAY..ST_ACK; REMAP_TIMEOUT_CYC.
- Sub-module key_press_detect: owns keys_q/keys_prev and emits press_valid, press_multi and key_onehot. Reused by the play-mode note generator.
- Popcount is computed inside key_press_detect as a small combinational function.

Test Plan:
- Reset then play: rst_n low 2 cycles, release; keys=7'b0000100 -> ram_addr=7'b0000100 two cycles later, ram_rw=0 throughout, busy=0.
- Normal remap: remap_en=1; press 7'b0000001, release; press 7'b0100000 -> exactly one cycle ram_rw=1, ram_addr=7'b0000001, ram_wdata=7'b0100000, done=1. After release, state_o=1.
- Multi-key reject: in SRC press 7'b0000011 -> err pulse 1 cycle, state_o stays 1, ram_rw never 1. Release, then press 7'b0000010 -> DST.
- Timeout: TIMEOUT_CYC=20; enter DST via press 7'b0001000, then idle -> err at cycle 20 after DST entry, state_o=1, no write issued.
- Abort: in DST, drop remap_en -> state_o=0 next cycle, no ram_rw pulse, no err. Re-enter remap -> starts at SRC with the counter at 0.
- Reset mid-write sequence: assert rst_n=0 while in DST -> next cycle all outputs 0, state_o=0. Drive ram_addr to the same key in play -> RAM returns the identity mapping.
